// File: rtl/paj7620_i2c_slave_pkg.sv
// Shared types and defaults for the PAJ7620 gesture-sensor I2C target model.
package paj7620_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEF  = 7'h73;
  localparam logic [7:0] GEST_ADDR_DEF = 8'h43;
  localparam logic [7:0] BANK_ADDR_DEF = 8'hEF;

  localparam int GEST_UP    = 0;
  localparam int GEST_DOWN  = 1;
  localparam int GEST_LEFT  = 2;
  localparam int GEST_RIGHT = 3;

  // States in which the target holds sda low for the ninth (ACK) bit.
  function automatic logic is_ack_state(state_t s);
    return (s == ADDR_ACK) || (s == REG_ACK) || (s == WDATA_ACK);
  endfunction

endpackage

// File: rtl/paj7620_i2c_slave_if.sv
// Application-side signals of the PAJ7620 target: gesture source in, register-write report out.
interface paj7620_i2c_slave_if;
  import paj7620_pkg::*;

  // Strobe-only handshakes, no ready/backpressure: gest_vld qualifies gest_in for exactly
  // the cycle it is high; wr_stb is a one-cycle pulse and wr_addr/wr_data are valid with it
  // and held until the next pulse. The consumer must accept every pulse.
  logic [7:0] gest_in;
  logic       gest_vld;
  logic       bank_sel;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  state_t     state_dbg;

  modport slave (
    input  gest_in, gest_vld,
    output bank_sel, wr_stb, wr_addr, wr_data, busy, state_dbg
  );

  modport master (
    output gest_in, gest_vld,
    input  bank_sel, wr_stb, wr_addr, wr_data, busy, state_dbg
  );

endinterface

// File: rtl/paj7620_i2c_slave_sync.sv
// Two-flop synchronisers for scl/sda plus START, STOP and scl edge pulses.
module i2c_bus_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Reset to the idle bus level so releasing reset cannot fake an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/paj7620_i2c_slave.sv
// PAJ7620 gesture-sensor I2C target: scratch registers, bank select and a
// clear-on-read gesture flag register behind a byte-level bus FSM.
module paj7620_i2c_slave
  import paj7620_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEF,
  parameter int         SCR_DEPTH = 16,
  parameter logic [7:0] GEST_ADDR = GEST_ADDR_DEF,
  parameter logic [7:0] BANK_ADDR = BANK_ADDR_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic scl,
  inout  wire  sda,
  paj7620_i2c_slave_if.slave app
);

  localparam int AW = $clog2(SCR_DEPTH);

  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [7:0] shreg, rd_hold, ptr, rd_byte, flags, flags_nxt;
  logic       ack_q, sda_oe, sda_oe_nxt, busy_q, bank;
  logic       wr_stb_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic       shift_in, shift_out, load_rd, reg_ld, wr_en, rd_sample, clr_gest;
  logic [7:0] scr [SCR_DEPTH];

  i2c_bus_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Byte boundaries are taken on the scl fall after the 8th (or ACK) rise.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else if (scl_fall) begin
      case (state)
        ADDR:      if (cnt == 4'd8) state_nxt = (shreg[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (cnt == 4'd1) state_nxt = shreg[0] ? RDATA : REG;
        REG:       if (cnt == 4'd8) state_nxt = REG_ACK;
        REG_ACK:   if (cnt == 4'd1) state_nxt = WDATA;
        WDATA:     if (cnt == 4'd8) state_nxt = WDATA_ACK;
        WDATA_ACK: if (cnt == 4'd1) state_nxt = WDATA;
        RDATA:     if (cnt == 4'd8) state_nxt = RDATA_ACK;
        RDATA_ACK: if (cnt == 4'd1) state_nxt = ack_q ? IGNORE : RDATA;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    sda_oe_nxt = sda_oe;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    load_rd    = 1'b0;
    reg_ld     = 1'b0;
    wr_en      = 1'b0;
    rd_sample  = 1'b0;
    if (start_det || stop_det) begin
      sda_oe_nxt = 1'b0;
    end else if (scl_rise) begin
      shift_in  = (state == ADDR) || (state == REG) || (state == WDATA);
      rd_sample = (state == RDATA_ACK);
    end else if (scl_fall) begin
      load_rd   = (state == ADDR_ACK  && cnt == 4'd1 && shreg[0]) ||
                  (state == RDATA_ACK && cnt == 4'd1 && !ack_q);
      shift_out = (state == RDATA) && (cnt != 4'd8);
      reg_ld    = (state == REG)   && (cnt == 4'd8);
      wr_en     = (state == WDATA) && (cnt == 4'd8);
      if (is_ack_state(state_nxt))  sda_oe_nxt = 1'b1;
      else if (state_nxt == RDATA)  sda_oe_nxt = load_rd ? ~rd_byte[7] : ~shreg[6];
      else                          sda_oe_nxt = 1'b0;
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    if ((ptr >> AW) == 8'd0)               rd_byte = scr[ptr[AW-1:0]];
    else if (ptr == BANK_ADDR)             rd_byte = {7'b0, bank};
    else if ((ptr == GEST_ADDR) && !bank)  rd_byte = flags;
  end

  // A gesture landing in the clearing cycle is ORed back in after the clear.
  assign clr_gest  = rd_sample && (ptr == GEST_ADDR) && !bank;
  assign flags_nxt = (clr_gest ? (flags & ~rd_hold) : flags) |
                     (app.gest_vld ? app.gest_in : 8'h00);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt       <= 4'd0;
      shreg     <= 8'h00;
      rd_hold   <= 8'h00;
      ptr       <= 8'h00;
      ack_q     <= 1'b0;
      sda_oe    <= 1'b0;
      busy_q    <= 1'b0;
      bank      <= 1'b0;
      flags     <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      sda_oe <= sda_oe_nxt;
      if (start_det || stop_det || (state_nxt != state)) cnt <= 4'd0;
      else if (scl_rise && (state != IDLE) && (state != IGNORE)) cnt <= cnt + 4'd1;
      if (shift_in)       shreg <= {shreg[6:0], sda_s};
      else if (load_rd)   shreg <= rd_byte;
      else if (shift_out) shreg <= {shreg[6:0], 1'b0};
      if (load_rd)   rd_hold <= rd_byte;
      if (rd_sample) ack_q   <= sda_s;
      if (reg_ld)                  ptr <= shreg;
      else if (wr_en || rd_sample) ptr <= ptr + 8'd1;
      if (start_det)     busy_q <= 1'b1;
      else if (stop_det) busy_q <= 1'b0;
      if (wr_en && (ptr == BANK_ADDR)) bank <= shreg[0];
      flags    <= flags_nxt;
      wr_stb_q <= wr_en;
      if (wr_en) begin
        wr_addr_q <= ptr;
        wr_data_q <= shreg;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SCR_DEPTH; i++) scr[i] <= 8'h00;
    end else if (wr_en && ((ptr >> AW) == 8'd0)) begin
      scr[ptr[AW-1:0]] <= shreg;
    end
  end

  assign app.bank_sel  = bank;
  assign app.wr_stb    = wr_stb_q;
  assign app.wr_addr   = wr_addr_q;
  assign app.wr_data   = wr_data_q;
  assign app.busy      = busy_q;
  assign app.state_dbg = state;

endmodule

// File: tb/tb_paj7620_i2c_slave.sv
// Directed bench for paj7620_i2c_slave: bit-banged I2C master, write/read scoreboards.
module tb_paj7620_i2c_slave;
  import paj7620_pkg::*;

  localparam int Q = 100;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic scl_r = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  int n_check = 0;
  int n_pass  = 0;

  logic [15:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];

  paj7620_i2c_slave_if app_if ();

  paj7620_i2c_slave dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .scl       (scl_r),
    .sda       (sda),
    .app       (app_if.slave)
  );

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge sys_clk) begin
    if (app_if.wr_stb === 1'b1) begin
      n_check++;
      assert (wr_exp_q.size() > 0) n_pass++;
      else $error("FAIL wr_unexpected observed=%h expected=none", {app_if.wr_addr, app_if.wr_data});
      if (wr_exp_q.size() > 0) check("wr_stb", {app_if.wr_addr, app_if.wr_data}, wr_exp_q.pop_front());
    end
  end

  task automatic i2c_start();
    m_low = 1'b0; #Q; scl_r = 1'b1; #Q; m_low = 1'b1; #Q; scl_r = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q; scl_r = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  // Optional gesture pulse lands exactly in the cycle the target samples this bit.
  task automatic write_bit(input logic b, input logic inj_vld, input logic [7:0] inj);
    m_low = ~b; #Q; scl_r = 1'b1;
    if (inj_vld) begin
      #20; app_if.gest_in = inj; app_if.gest_vld = 1'b1;
      #10; app_if.gest_vld = 1'b0; app_if.gest_in = 8'h00;
      #(2*Q-30);
    end else begin
      #(2*Q);
    end
    scl_r = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #Q; scl_r = 1'b1; #Q; b = sda; #Q; scl_r = 1'b0; #Q;
  endtask

  task automatic wb(input string tag, input logic [7:0] d, input logic exp_ack);
    logic ack;
    for (int i = 7; i >= 0; i--) write_bit(d[i], 1'b0, 8'h00);
    read_bit(ack);
    check(tag, {15'b0, ack}, {15'b0, exp_ack});
  endtask

  task automatic rd_chk(input string tag, input logic nack, input logic inj_vld, input logic [7:0] inj);
    logic [7:0] d;
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack, inj_vld, inj);
    check(tag, {8'h00, d}, {8'h00, rd_exp_q.pop_front()});
  endtask

  task automatic rd_setup(input logic [7:0] addr);
    i2c_start();
    wb("ack_addr_w", 8'hE6, 1'b0);
    wb("ack_reg", addr, 1'b0);
    i2c_start();
    wb("ack_addr_r", 8'hE7, 1'b0);
  endtask

  task automatic read_reg(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    rd_exp_q.push_back(exp);
    rd_setup(addr);
    rd_chk(tag, 1'b1, 1'b0, 8'h00);
    i2c_stop();
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    wr_exp_q.push_back({addr, data});
    i2c_start();
    wb("ack_addr_w", 8'hE6, 1'b0);
    wb("ack_reg", addr, 1'b0);
    wb("ack_data", data, 1'b0);
    i2c_stop();
  endtask

  task automatic gest(input logic [7:0] g);
    @(negedge sys_clk); app_if.gest_in = g; app_if.gest_vld = 1'b1;
    @(negedge sys_clk); app_if.gest_vld = 1'b0; app_if.gest_in = 8'h00;
  endtask

  initial begin
    logic b;
    app_if.gest_in  = 8'h00;
    app_if.gest_vld = 1'b0;
    #100; sys_rst_n = 1'b1; #100;

    check("rst_sda", {15'b0, sda}, 16'h0001);
    check("rst_busy", {15'b0, app_if.busy}, 16'h0000);
    check("rst_bank", {15'b0, app_if.bank_sel}, 16'h0000);
    check("rst_wr", {7'b0, app_if.wr_stb, app_if.wr_addr}, 16'h0000);
    check("rst_state", {12'b0, app_if.state_dbg}, {12'b0, IDLE});

    // Two-byte scratch write with auto-increment, then read back across a repeated START.
    wr_exp_q.push_back(16'h05A5);
    wr_exp_q.push_back(16'h063C);
    i2c_start();
    wb("ack_addr", 8'hE6, 1'b0);
    check("busy_on", {15'b0, app_if.busy}, 16'h0001);
    wb("ack_reg", 8'h05, 1'b0);
    wb("ack_d0", 8'hA5, 1'b0);
    wb("ack_d1", 8'h3C, 1'b0);
    i2c_stop(); #50;
    check("busy_off", {15'b0, app_if.busy}, 16'h0000);
    rd_exp_q.push_back(8'hA5);
    rd_exp_q.push_back(8'h3C);
    rd_setup(8'h05);
    rd_chk("rd_scr0", 1'b0, 1'b0, 8'h00);
    rd_chk("rd_scr1", 1'b1, 1'b0, 8'h00);
    i2c_stop();

    // Foreign address: NACK and ignored data, then a normal transaction.
    i2c_start();
    wb("nack_addr", 8'hE4, 1'b1);
    wb("nack_data", 8'h05, 1'b1);
    i2c_stop();
    write_reg(8'h07, 8'h5A);
    read_reg("rd_after_nack", 8'h07, 8'h5A);

    // Gesture flags clear on read; a same-cycle gesture survives the clear.
    gest(8'(1 << GEST_UP));
    gest(8'(1 << GEST_LEFT));
    read_reg("gest_first", 8'h43, 8'h05);
    read_reg("gest_cleared", 8'h43, 8'h00);
    gest(8'h03);
    rd_exp_q.push_back(8'h03);
    rd_setup(8'h43);
    rd_chk("gest_race_rd", 1'b1, 1'b1, 8'(1 << GEST_DOWN));
    i2c_stop();
    read_reg("gest_survive", 8'h43, 8'h02);

    // Bank 1 hides the flags without clearing them; writes to 0x43 do not touch them.
    gest(8'(1 << GEST_RIGHT));
    write_reg(8'h43, 8'hFF);
    write_reg(8'hEF, 8'h01); #50;
    check("bank_set", {15'b0, app_if.bank_sel}, 16'h0001);
    read_reg("gest_bank1", 8'h43, 8'h00);
    read_reg("bank_rd", 8'hEF, 8'h01);
    write_reg(8'hEF, 8'h00); #50;
    check("bank_clr", {15'b0, app_if.bank_sel}, 16'h0000);
    read_reg("gest_bank0", 8'h43, 8'h08);

    // STOP inside a data byte discards it.
    write_reg(8'h09, 8'h77);
    i2c_start();
    wb("ack_addr", 8'hE6, 1'b0);
    wb("ack_reg", 8'h09, 1'b0);
    for (int i = 0; i < 4; i++) write_bit(1'b1, 1'b0, 8'h00);
    i2c_stop(); #40;
    check("partial_busy", {15'b0, app_if.busy}, 16'h0000);
    check("partial_sda", {15'b0, sda}, 16'h0001);
    read_reg("partial_keep", 8'h09, 8'h77);

    // Reset while the target is driving a 0 read bit.
    write_reg(8'hEF, 8'h01);
    write_reg(8'h02, 8'h0F);
    rd_setup(8'h02);
    read_bit(b);
    read_bit(b);
    check("rd_drive_low", {15'b0, sda}, 16'h0000);
    sys_rst_n = 1'b0;
    #1;
    check("rstrd_sda", {15'b0, sda}, 16'h0001);
    check("rstrd_busy", {15'b0, app_if.busy}, 16'h0000);
    check("rstrd_bank", {15'b0, app_if.bank_sel}, 16'h0000);
    check("rstrd_wr", {app_if.wr_addr, app_if.wr_data}, 16'h0000);
    check("rstrd_state", {12'b0, app_if.state_dbg}, {12'b0, IDLE});
    #9;
    m_low = 1'b0; scl_r = 1'b1;
    #100; sys_rst_n = 1'b1; #100;
    read_reg("rstrd_scr", 8'h02, 8'h00);
    read_reg("rstrd_scr5", 8'h05, 8'h00);

    #200;
    check("wr_q_empty", 16'(wr_exp_q.size()), 16'h0000);
    check("rd_q_empty", 16'(rd_exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
